// File: rtl/mult_result_buf_pkg.sv
// rtl/mult_result_buf_pkg.sv - system-wide result packet type and multiplier buffer defaults
// Stands in for sys_defs.svh: FU_PACKET, DATA width, MULT_STAGES and the default buffer depth.
package mult_result_buf_pkg;

   localparam int DATA_W         = 32;
   localparam int PRN_W          = 6;
   localparam int ROB_W          = 5;
   localparam int MULT_STAGES    = 4;
   localparam int MULT_BUF_DEPTH = 2;

   typedef struct packed {
      logic [DATA_W-1:0] alu_result;
      logic [PRN_W-1:0]  dest_prn;
      logic [ROB_W-1:0]  rob_idx;
      logic              take_branch;
   } FU_PACKET;

endpackage

// File: rtl/mult_result_buf.sv
// rtl/mult_result_buf.sv - result queue between the pipelined multiplier and the CDB arbiter
// Optional same-cycle bypass of an empty queue is enabled by defining MULT_BUF_BYPASS_EN.
module mult_result_buf
   import mult_result_buf_pkg::*;
#(
   parameter int  DEPTH = MULT_BUF_DEPTH,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             i_in_valid,
   input  FU_PACKET         i_in_pack,
   input  logic             i_squash,
   input  logic             i_cdb_grant,
   output logic             o_mult_stall,
   output logic             o_cdb_req,
   output FU_PACKET         o_out_pack,
   output logic [CNT_W-1:0] o_count
);

   localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   FU_PACKET [DEPTH-1:0] r_mem;
   logic [PTR_W-1:0]     r_head;
   logic [PTR_W-1:0]     r_tail;
   logic [CNT_W-1:0]     r_count;

   logic w_empty;
   logic w_full;
   logic w_bypass;
   logic w_pop;
   logic w_accept;
   logic w_push;
   logic w_deq;

   always_comb begin
      w_empty = (r_count == '0);
      w_full  = (r_count == FULL_CNT);
`ifdef MULT_BUF_BYPASS_EN
      w_bypass = w_empty & i_in_valid & ~i_squash;
`else
      w_bypass = 1'b0;
`endif
      o_cdb_req    = (~w_empty | w_bypass) & ~i_squash;
      w_pop        = o_cdb_req & i_cdb_grant;
      o_mult_stall = w_full & ~w_pop & ~i_squash;
      w_accept     = i_in_valid & ~o_mult_stall & ~i_squash;
      // A granted bypass is consumed straight off the input; storage is untouched.
      w_push       = w_accept & ~(w_bypass & i_cdb_grant);
      w_deq        = w_pop & ~w_bypass;
      if (!w_empty) begin
         o_out_pack = r_mem[r_head];
      end else if (w_bypass) begin
         o_out_pack = i_in_pack;
      end else begin
         o_out_pack = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mem   <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_squash) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_tail] <= i_in_pack;
            r_tail        <= (r_tail == LAST_PTR) ? '0 : r_tail + 1'b1;
         end
         if (w_deq) begin
            r_head <= (r_head == LAST_PTR) ? '0 : r_head + 1'b1;
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_deq);
      end
   end

   assign o_count = r_count;

   // The multiplier must hold its result while stalled; dropping it loses a result.
   a_hold_while_stalled: assert property (@(posedge clock) disable iff (reset)
      (i_in_valid && o_mult_stall) |=> (i_in_valid || i_squash || reset));

   a_count_bound: assert property (@(posedge clock) r_count <= FULL_CNT);

endmodule

// File: tb/tb_mult_result_buf.sv
// tb/tb_mult_result_buf.sv - directed self-checking bench for mult_result_buf
// Expectations follow MULT_BUF_BYPASS_EN when it is defined for the build.
module tb_mult_result_buf;
   import mult_result_buf_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic       in_valid;
   FU_PACKET   in_pack;
   logic       squash;
   logic       grant;
   logic       mult_stall;
   logic       cdb_req;
   FU_PACKET   out_pack;
   logic [1:0] count;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   mult_result_buf dut (
      .clock        (clock),
      .reset        (reset),
      .i_in_valid   (in_valid),
      .i_in_pack    (in_pack),
      .i_squash     (squash),
      .i_cdb_grant  (grant),
      .o_mult_stall (mult_stall),
      .o_cdb_req    (cdb_req),
      .o_out_pack   (out_pack),
      .o_count      (count)
   );

   function automatic FU_PACKET mk(input logic [31:0] v);
      FU_PACKET p;
      p.alu_result  = v;
      p.dest_prn    = v[5:0] ^ 6'h15;
      p.rob_idx     = v[4:0];
      p.take_branch = v[0];
      return p;
   endfunction

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic mid();
      @(negedge clock);
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_pack = mk(32'h1234); squash = 1'b0; grant = 1'b0;
      cyc(); cyc(); mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
      total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", cdb_req); end
      total++; if (mult_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", mult_stall); end
      total++; if (out_pack !== FU_PACKET'('0)) begin bad++; $display("FAIL reset_out: got %h want 0", out_pack); end
      cyc();
      reset = 1'b0; in_pack = '0;
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_pack = mk(32'h6); grant = 1'b1;
      mid();
`ifdef MULT_BUF_BYPASS_EN
      total++; if (cdb_req !== 1'b1) begin bad++; $display("FAIL single_req_n: got %b want 1", cdb_req); end
      total++; if (out_pack !== mk(32'h6)) begin bad++; $display("FAIL single_out_n: got %h want %h", out_pack, mk(32'h6)); end
`else
      total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL single_req_n: got %b want 0", cdb_req); end
`endif
      cyc();
      in_valid = 1'b0; in_pack = '0;
      mid();
`ifdef MULT_BUF_BYPASS_EN
      total++; if (count !== 2'd0) begin bad++; $display("FAIL single_count_n1: got %0d want 0", count); end
`else
      total++; if (cdb_req !== 1'b1) begin bad++; $display("FAIL single_req_n1: got %b want 1", cdb_req); end
      total++; if (out_pack.alu_result !== 32'h6) begin bad++; $display("FAIL single_out_n1: got %h want 6", out_pack.alu_result); end
      total++; if (count !== 2'd1) begin bad++; $display("FAIL single_count_n1: got %0d want 1", count); end
`endif
      cyc(); mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL single_count_n2: got %0d want 0", count); end
      total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL single_req_n2: got %b want 0", cdb_req); end
      cyc();
      grant = 1'b0;
   endtask

   task automatic test_fill_and_order();
      grant = 1'b0;
      in_valid = 1'b1; in_pack = mk(32'hA);
      cyc();
      in_pack = mk(32'hB);
      mid();
      total++; if (count !== 2'd1) begin bad++; $display("FAIL fill_count1: got %0d want 1", count); end
      total++; if (mult_stall !== 1'b0) begin bad++; $display("FAIL fill_stall1: got %b want 0", mult_stall); end
      cyc();
      in_pack = mk(32'hC);
      mid();
      total++; if (count !== 2'd2) begin bad++; $display("FAIL fill_count2: got %0d want 2", count); end
      total++; if (mult_stall !== 1'b1) begin bad++; $display("FAIL fill_stall_c: got %b want 1", mult_stall); end
      total++; if (cdb_req !== 1'b1) begin bad++; $display("FAIL fill_req: got %b want 1", cdb_req); end
      cyc();
      grant = 1'b1;
      mid();
      total++; if (count !== 2'd2) begin bad++; $display("FAIL fill_count_held: got %0d want 2", count); end
      total++; if (mult_stall !== 1'b0) begin bad++; $display("FAIL fill_stall_grant: got %b want 0", mult_stall); end
      total++; if (out_pack !== mk(32'hA)) begin bad++; $display("FAIL drain_a: got %h want %h", out_pack, mk(32'hA)); end
      cyc();
      in_valid = 1'b0; in_pack = '0;
      mid();
      total++; if (count !== 2'd2) begin bad++; $display("FAIL pop_accept_count: got %0d want 2", count); end
      total++; if (out_pack !== mk(32'hB)) begin bad++; $display("FAIL drain_b: got %h want %h", out_pack, mk(32'hB)); end
      cyc(); mid();
      total++; if (count !== 2'd1) begin bad++; $display("FAIL drain_count1: got %0d want 1", count); end
      total++; if (out_pack !== mk(32'hC)) begin bad++; $display("FAIL drain_c: got %h want %h", out_pack, mk(32'hC)); end
      cyc(); mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL drain_empty: got %0d want 0", count); end
      total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL empty_req: got %b want 0", cdb_req); end
      total++; if (out_pack !== FU_PACKET'('0)) begin bad++; $display("FAIL empty_out: got %h want 0", out_pack); end
      cyc(); mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL grant_ignored: got %0d want 0", count); end
      cyc();
      grant = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] q[$];
      grant = 1'b0; in_valid = 1'b1;
      in_pack = mk(32'h100); cyc(); q.push_back(32'h100);
      in_pack = mk(32'h101); cyc(); q.push_back(32'h101);
      grant = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_pack = mk(32'h102 + k);
         mid();
         total++; if (mult_stall !== 1'b0) begin bad++; $display("FAIL b2b_stall[%0d]: got %b want 0", k, mult_stall); end
         total++; if (count !== 2'd2) begin bad++; $display("FAIL b2b_count[%0d]: got %0d want 2", k, count); end
         total++; if (out_pack !== mk(q[0])) begin bad++; $display("FAIL b2b_out[%0d]: got %h want %h", k, out_pack, mk(q[0])); end
         cyc();
         void'(q.pop_front());
         q.push_back(32'h102 + k);
      end
      in_valid = 1'b0; in_pack = '0;
      for (int k = 0; k < 2; k++) begin
         mid();
         total++; if (out_pack !== mk(q[0])) begin bad++; $display("FAIL b2b_drain[%0d]: got %h want %h", k, out_pack, mk(q[0])); end
         cyc();
         void'(q.pop_front());
      end
      mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL b2b_empty: got %0d want 0", count); end
      cyc();
      grant = 1'b0;
   endtask

   task automatic test_squash();
      grant = 1'b0; in_valid = 1'b1;
      in_pack = mk(32'h200); cyc();
      in_pack = mk(32'h201); cyc();
      squash = 1'b1; in_pack = mk(32'h2FF); grant = 1'b1;
      mid();
      total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL squash_req: got %b want 0", cdb_req); end
      total++; if (mult_stall !== 1'b0) begin bad++; $display("FAIL squash_stall: got %b want 0", mult_stall); end
      cyc();
      squash = 1'b0; in_valid = 1'b0; in_pack = '0; grant = 1'b0;
      mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL squash_count: got %0d want 0", count); end
      total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL squash_req_after: got %b want 0", cdb_req); end
      cyc();
      in_valid = 1'b1; in_pack = mk(32'h300);
      cyc();
      in_valid = 1'b0; in_pack = '0; grant = 1'b1;
      mid();
      total++; if (count !== 2'd1) begin bad++; $display("FAIL post_squash_count: got %0d want 1", count); end
      total++; if (out_pack !== mk(32'h300)) begin bad++; $display("FAIL post_squash_out: got %h want %h", out_pack, mk(32'h300)); end
      total++; if (dut.r_mem[0] !== mk(32'h300)) begin bad++; $display("FAIL post_squash_idx0: got %h want %h", dut.r_mem[0], mk(32'h300)); end
      cyc(); mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL post_squash_drain: got %0d want 0", count); end
      cyc();
      grant = 1'b0;
   endtask

   task automatic test_bypass();
      in_valid = 1'b1; in_pack = mk(32'h77); grant = 1'b1;
      mid();
`ifdef MULT_BUF_BYPASS_EN
      total++; if (cdb_req !== 1'b1) begin bad++; $display("FAIL bypass_req: got %b want 1", cdb_req); end
      total++; if (out_pack !== mk(32'h77)) begin bad++; $display("FAIL bypass_out: got %h want %h", out_pack, mk(32'h77)); end
      cyc();
      in_valid = 1'b0; in_pack = '0;
      mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL bypass_count: got %0d want 0", count); end
`else
      total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL bypass_req: got %b want 0", cdb_req); end
      cyc();
      in_valid = 1'b0; in_pack = '0;
      mid();
      total++; if (cdb_req !== 1'b1) begin bad++; $display("FAIL bypass_req_n1: got %b want 1", cdb_req); end
      total++; if (out_pack !== mk(32'h77)) begin bad++; $display("FAIL bypass_out_n1: got %h want %h", out_pack, mk(32'h77)); end
      cyc(); mid();
      total++; if (count !== 2'd0) begin bad++; $display("FAIL bypass_count: got %0d want 0", count); end
`endif
      cyc();
      grant = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_and_order();
      test_back_to_back();
      test_squash();
      test_bypass();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
